modexp_seq: RTL and testbench
=============================

# modexp_seq

Parametrised modular-exponentiation sequencer computing m = c^d mod n by left-to-right binary square-and-multiply in the Montgomery domain. It holds the operand limb stores, scans the exponent and drives an external Montgomery-product (MonPro) core through a limb-streaming handshake. It supersedes the fixed-width controller with configurable limb width and count, explicit start/busy/done handshaking, back-pressured result streaming, and defined zero-exponent behaviour.

## Interface
- DATA_WIDTH, 64, limb width in bits
- LIMBS, 32, limbs per modulus-sized operand; the operand is DATA_WIDTH*LIMBS bits
- EXP_LIMBS, 32, limbs of exponent d
- AW, $clog2(LIMBS>EXP_LIMBS?LIMBS:EXP_LIMBS), limb address width
---
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- ld_en  in  1  write strobe for a load limb
- ld_sel  in  2  target store: 0=c, 1=t (R^2 mod n), 2=r (R mod n), 3=d
- ld_addr  in  AW  limb index, LSB limb = 0
- ld_data  in  DATA_WIDTH  limb value
- start  in  1  begin exponentiation; sampled only in IDLE
- busy  out  1  high from the cycle after accepted start until return to IDLE
- done  out  1  one-cycle pulse when the last result limb is accepted
- res_valid  out  1  result limb valid
- res_ready  in  1  result limb accepted when res_valid && res_ready
- res_data  out  DATA_WIDTH  result limb, LSB limb first
- mp_start  out  1  one-cycle pulse opening a MonPro operation
- mp_in_valid  out  1  operand limb valid (A limbs 0..LIMBS-1, then B limbs 0..LIMBS-1)
- mp_in_data  out  DATA_WIDTH  operand limb
- mp_out_valid  in  1  result limb from MonPro, LIMBS beats, LSB first, no back-pressure
- mp_out_data  in  DATA_WIDTH  MonPro result limb

## Operation
- Stores: cbar[LIMBS], mbar[LIMBS], t[LIMBS], d[EXP_LIMBS]. A load with ld_sel=0 writes cbar; ld_sel=2 writes mbar. ld_en is ignored while busy. Loads with ld_addr beyond the store depth are dropped.
- States: IDLE, CBAR, SCAN, SQR, MUL, FINAL, OUT. Every MonPro state runs the sub-sequence ISSUE_A (LIMBS beats) -> ISSUE_B (LIMBS beats) -> COLLECT (LIMBS mp_out_valid beats) -> next state.
- IDLE: on start, go to CBAR. The bit pointer bp is set to EXP_LIMBS*DATA_WIDTH-1.
- CBAR: computes cbar = MonPro(cbar, t), then goes to SCAN.
- SCAN: evaluates one bit per cycle.
  - If d[bp]==1, go to SQR.
  - Else if bp==0, go to FINAL. d=0 gives result 1.
  - Else decrement bp.
- SQR: computes mbar = MonPro(mbar, mbar).
  - Go to MUL if d[bp]==1.
  - Otherwise, if bp==0 go to FINAL; else decrement bp and go to SQR.
- MUL: computes mbar = MonPro(mbar, cbar). Then, if bp==0 go to FINAL; else decrement bp and go to SQR.
- FINAL: computes mbar = MonPro(mbar, 1), where B is limb0=1 and all other limbs 0. Then go to OUT.
- OUT: streams mbar[0..LIMBS-1] on res_*. After the last handshake, pulse done and go to IDLE.
- The exponent and t stores survive a run. cbar and mbar are overwritten by the run and must be reloaded before the next run.
- Reset:
  - State goes to IDLE.
  - busy, done, res_valid, mp_start and mp_in_valid are 0.
  - res_data and mp_in_data are 0.
  - bp and the limb counters are 0.
  - Store contents are undefined.
  - Reset mid-operation aborts immediately. Any MonPro beats arriving afterwards are ignored.

## Timing
- Cycle 0 is the cycle start is sampled in IDLE.
- busy=1 from cycle 1. mp_start pulses in cycle 1, with A limb 0 on mp_in in the same cycle.
- mp_in_valid is high for exactly 2*LIMBS consecutive cycles per operation, with no gaps.
- COLLECT writes a limb on each mp_out_valid beat. The destination limb is updated in the cycle after its beat.
- The next mp_start may be issued no earlier than the cycle after the last COLLECT beat.
- mp_out_valid outside COLLECT is ignored.
- SCAN costs 1 cycle per leading-zero bit.
- OUT presents limb k until it is accepted. The first res_valid is in the cycle after the last FINAL beat. With res_ready held high, OUT takes LIMBS cycles.
- done is asserted in the cycle after the final handshake, the same cycle busy falls.
- A start arriving while busy, or in the cycle done is high, is ignored.

## Configuration
- MODEXP_CONST_TIME_EN defined:
  - SCAN is bypassed; CBAR goes directly to SQR with bp at the exponent MSB.
  - MUL is executed for every bit. When d[bp]==0 its COLLECT beats are discarded and mbar is unchanged.
  - The operation count is fixed at 2*EXP_LIMBS*DATA_WIDTH+2 MonPro runs, independent of d.
- Undefined: leading-zero skip and conditional MUL, as described above.

## Test plan
Bench setup: DATA_WIDTH=8, LIMBS=2, EXP_LIMBS=2, n=241, R=2^16. A behavioural MonPro model with a fixed 5-cycle latency is used, and t/r are precomputed by the bench.
- c=5, d=3 -> result limbs {0x7D,0x00} (125). The run uses 6 MonPro ops undefined, or 34 ops with MODEXP_CONST_TIME_EN.
- c=2, d=10 -> result 60. No mp_in_valid gaps are allowed.
- d=0 -> result 1. With the macro undefined, SQR/MUL are never entered.
- Assert start twice during a run -> only one run occurs. busy stays high and the second start produces no effect.
- Hold res_ready low for 7 cycles in OUT -> res_data is stable with res_valid held, and done appears only after the 2nd handshake.
- Assert reset during SQR COLLECT -> all outputs go to reset values the next cycle. A reload followed by start then yields the correct result.

Source files
------------

// File: rtl/modexp_if.sv
// modexp_if: load, control, result-stream and MonPro-stream signals of modexp_seq
interface modexp_if #(
  parameter int DATA_WIDTH = 64,
  parameter int AW = 5
);
  logic ld_en;
  logic [1:0] ld_sel;
  logic [AW-1:0] ld_addr;
  logic [DATA_WIDTH-1:0] ld_data;
  logic start;
  logic busy;
  logic done;
  logic res_valid;
  logic res_ready;
  logic [DATA_WIDTH-1:0] res_data;
  logic mp_start;
  logic mp_in_valid;
  logic [DATA_WIDTH-1:0] mp_in_data;
  logic mp_out_valid;
  logic [DATA_WIDTH-1:0] mp_out_data;
  modport slave (
    input ld_en, ld_sel, ld_addr, ld_data, start, res_ready, mp_out_valid, mp_out_data,
    output busy, done, res_valid, res_data, mp_start, mp_in_valid, mp_in_data
  );
  modport master (
    output ld_en, ld_sel, ld_addr, ld_data, start, res_ready, mp_out_valid, mp_out_data,
    input busy, done, res_valid, res_data, mp_start, mp_in_valid, mp_in_data
  );
endinterface

// File: rtl/modexp_seq.sv
// modexp_seq: Montgomery-domain square-and-multiply sequencer driving an external MonPro core.
// Define MODEXP_CONST_TIME_EN for a fixed SQR+MUL schedule independent of the exponent.
module modexp_seq #(
  parameter int DATA_WIDTH = 64,
  parameter int LIMBS = 32,
  parameter int EXP_LIMBS = 32,
  parameter int AW = $clog2(LIMBS > EXP_LIMBS ? LIMBS : EXP_LIMBS)
) (
  input logic clk,
  input logic reset,
  modexp_if.slave bus
);
`ifdef MODEXP_CONST_TIME_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif
  localparam int LW = LIMBS > 1 ? $clog2(LIMBS) : 1;
  localparam int EW = EXP_LIMBS > 1 ? $clog2(EXP_LIMBS) : 1;
  localparam int NB = EXP_LIMBS * DATA_WIDTH;
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  localparam logic [LW-1:0] LAST = LW'(LIMBS - 1);
  localparam logic [BW-1:0] MSB = BW'(NB - 1);
  typedef enum logic [2:0] {IDLE, CBAR, SCAN, SQR, MUL, FINAL, OUT} state_t;
  typedef enum logic [1:0] {ISSUE_A, ISSUE_B, COLLECT} phase_t;
  state_t state, state_n;
  phase_t ph, ph_n;
  logic [LW-1:0] cnt, cnt_n;
  logic [BW-1:0] bp, bp_n;
  logic done_q, done_n;
  logic [DATA_WIDTH-1:0] cbar [LIMBS];
  logic [DATA_WIDTH-1:0] mbar [LIMBS];
  logic [DATA_WIDTH-1:0] t [LIMBS];
  logic [DATA_WIDTH-1:0] d_mem [EXP_LIMBS];
  logic [NB-1:0] d_flat;
  logic bit_d, mp_op, last, ld_w, ld_ok, ld_dok, wr;
  for (genvar i = 0; i < EXP_LIMBS; i++) begin : g_d
    assign d_flat[i*DATA_WIDTH +: DATA_WIDTH] = d_mem[i];
  end
  assign bit_d = d_flat[bp];
  assign mp_op = state inside {CBAR, SQR, MUL, FINAL};
  assign last = cnt == LAST;
  assign ld_w = bus.ld_en && state == IDLE;
  assign ld_ok = {1'b0, bus.ld_addr} < (AW+1)'(LIMBS);
  assign ld_dok = {1'b0, bus.ld_addr} < (AW+1)'(EXP_LIMBS);
  // constant-time MUL still runs for zero bits, but its product is thrown away
  assign wr = mp_op && ph == COLLECT && bus.mp_out_valid && (!CT || state != MUL || bit_d);
  assign bus.busy = state != IDLE;
  assign bus.done = done_q;
  assign bus.res_valid = state == OUT;
  assign bus.res_data = bus.res_valid ? mbar[cnt] : '0;
  assign bus.mp_start = mp_op && ph == ISSUE_A && cnt == '0;
  assign bus.mp_in_valid = mp_op && ph != COLLECT;
  assign bus.mp_in_data = !bus.mp_in_valid ? '0 :
                          ph == ISSUE_A ? (state == CBAR ? cbar[cnt] : mbar[cnt]) :
                          state == CBAR ? t[cnt] :
                          state == SQR ? mbar[cnt] :
                          state == MUL ? cbar[cnt] : DATA_WIDTH'(cnt == '0);
  always_comb begin
    state_n = state;
    ph_n = ph;
    cnt_n = cnt;
    bp_n = bp;
    done_n = 1'b0;
    if (state == IDLE) begin
      if (bus.start && !done_q) begin
        state_n = CBAR;
        ph_n = ISSUE_A;
        cnt_n = '0;
        bp_n = MSB;
      end
    end else if (state == SCAN) begin
      if (bit_d) state_n = SQR;
      else if (bp == '0) state_n = FINAL;
      else bp_n = bp - 1'b1;
    end else if (state == OUT) begin
      if (bus.res_ready) begin
        cnt_n = last ? '0 : cnt + 1'b1;
        state_n = last ? IDLE : OUT;
        done_n = last;
      end
    end else if (ph != COLLECT || bus.mp_out_valid) begin
      cnt_n = last ? '0 : cnt + 1'b1;
      if (last) begin
        ph_n = ph == ISSUE_A ? ISSUE_B : ph == ISSUE_B ? COLLECT : ISSUE_A;
        if (ph == COLLECT) begin
          if (state == CBAR) state_n = CT ? SQR : SCAN;
          else if (state == FINAL) state_n = OUT;
          else if (state == SQR && (CT || bit_d)) state_n = MUL;
          else if (bp == '0) state_n = FINAL;
          else begin
            state_n = SQR;
            bp_n = bp - 1'b1;
          end
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ph <= ISSUE_A;
      cnt <= '0;
      bp <= '0;
      done_q <= 1'b0;
    end else begin
      state <= state_n;
      ph <= ph_n;
      cnt <= cnt_n;
      bp <= bp_n;
      done_q <= done_n;
    end
  end
  always_ff @(posedge clk) begin
    if (ld_w && ld_ok && bus.ld_sel == 2'd0) cbar[bus.ld_addr[LW-1:0]] <= bus.ld_data;
    if (ld_w && ld_ok && bus.ld_sel == 2'd1) t[bus.ld_addr[LW-1:0]] <= bus.ld_data;
    if (ld_w && ld_ok && bus.ld_sel == 2'd2) mbar[bus.ld_addr[LW-1:0]] <= bus.ld_data;
    if (ld_w && ld_dok && bus.ld_sel == 2'd3) d_mem[bus.ld_addr[EW-1:0]] <= bus.ld_data;
    if (wr && state == CBAR) cbar[cnt] <= bus.mp_out_data;
    if (wr && state != CBAR) mbar[cnt] <= bus.mp_out_data;
  end
endmodule

// File: tb/tb_modexp_seq.sv
// tb_modexp_seq: randomized self-checking bench with a 5-cycle MonPro model and modexp reference.
`timescale 1ns/1ps
module tb_modexp_seq;
  localparam int DW = 8;
  localparam int L = 2;
  localparam int EL = 2;
  localparam int AW = 1;
  localparam longint N = 241;
  localparam longint R = 65536;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  modexp_if #(.DATA_WIDTH(DW), .AW(AW)) m ();
  modexp_seq #(.DATA_WIDTH(DW), .LIMBS(L), .EXP_LIMBS(EL), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(m));
  int passed = 0;
  int total = 0;
  longint rinv, tval, rval;
  int ops = 0, gaps = 0, early = 0;
  int in_cnt = 0, lat = 0, out_cnt = 0;
  bit cap = 0;
  logic [15:0] a_v, b_v, p_v;

  // external MonPro core: A then B limbs, product a*b/R mod n after 5 idle cycles
  always @(negedge clk) begin
    m.mp_out_valid = 1'b0;
    m.mp_out_data = '0;
    if (out_cnt > 0) begin
      m.mp_out_valid = 1'b1;
      m.mp_out_data = p_v[(L-out_cnt)*DW +: DW];
      out_cnt--;
    end else if (lat > 0) begin
      lat--;
      if (lat == 0) out_cnt = L;
    end
    if (m.mp_start) begin
      if (cap || lat > 0 || out_cnt > 0) early++;
      cap = 1;
      in_cnt = 0;
      ops++;
    end
    if (cap) begin
      if (!m.mp_in_valid) begin
        gaps++;
        cap = 0;
      end else begin
        if (in_cnt < L) a_v[in_cnt*DW +: DW] = m.mp_in_data;
        else b_v[(in_cnt-L)*DW +: DW] = m.mp_in_data;
        in_cnt++;
        if (in_cnt == 2*L) begin
          cap = 0;
          p_v = 16'(((longint'(a_v) * longint'(b_v)) % N) * rinv % N);
          lat = 5;
        end
      end
    end else if (m.mp_in_valid) gaps++;
  end

  function automatic longint ref_exp(longint c, longint d);
    longint r = 1;
    for (longint i = 0; i < d; i++) r = (r * c) % N;
    return r;
  endfunction

  function automatic int exp_ops(int d);
`ifdef MODEXP_CONST_TIME_EN
    return 2*EL*DW + 2;
`else
    return d == 0 ? 2 : 2 + $clog2(d + 1) + $countones(d);
`endif
  endfunction

  task automatic load_sel(input int s, input int v);
    logic [15:0] w;
    w = 16'(v);
    for (int k = 0; k < L; k++) begin
      @(negedge clk);
      m.ld_en = 1'b1;
      m.ld_sel = 2'(s);
      m.ld_addr = AW'(k);
      m.ld_data = w[k*DW +: DW];
    end
    @(negedge clk);
    m.ld_en = 1'b0;
  endtask

  task automatic load(input int c, input int d);
    load_sel(0, c);
    load_sel(1, int'(tval));
    load_sel(2, int'(rval));
    load_sel(3, d);
  endtask

  task automatic run(output logic [15:0] res, output int nops, output int bad, output logic [2:0] c1,
                     output logic [7:0] c1d, output bit dn, output bit tmo);
    int o0, g0, e0, k;
    bit fin;
    o0 = ops; g0 = gaps; e0 = early; k = 0; fin = 0;
    res = '0; dn = 0; tmo = 1;
    @(negedge clk);
    m.start = 1'b1;
    @(negedge clk);
    m.start = 1'b0;
    c1 = {m.busy, m.mp_start, m.mp_in_valid};
    c1d = m.mp_in_data;
    for (int cyc = 0; cyc < 4000 && tmo; cyc++) begin
      if (fin) begin
        dn = m.done && !m.busy;
        tmo = 0;
      end else if (m.res_valid && m.res_ready) begin
        res[k*DW +: DW] = m.res_data;
        k++;
        fin = k == L;
      end
      if (tmo) @(negedge clk);
    end
    nops = ops - o0;
    bad = (gaps - g0) + (early - e0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++; if ({m.busy, m.done, m.res_valid, m.mp_start, m.mp_in_valid} !== 5'b0) $display("FAIL reset_ctrl got=%b want=00000", {m.busy, m.done, m.res_valid, m.mp_start, m.mp_in_valid}); else passed++;
    total++; if (m.res_data !== 8'h00) $display("FAIL reset_res_data got=%h want=00", m.res_data); else passed++;
    total++; if (m.mp_in_data !== 8'h00) $display("FAIL reset_mp_in_data got=%h want=00", m.mp_in_data); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_known(input int c, input int d, input logic [15:0] expv);
    logic [15:0] res; int nops, bad; logic [2:0] c1; logic [7:0] c1d; bit dn, tmo;
    load(c, d);
    run(res, nops, bad, c1, c1d, dn, tmo);
    total++; if (tmo) $display("FAIL known_timeout c=%0d d=%0d", c, d); else passed++;
    total++; if (res !== expv) $display("FAIL known_result c=%0d d=%0d got=%0d want=%0d", c, d, res, expv); else passed++;
    total++; if (nops != exp_ops(d)) $display("FAIL known_ops d=%0d got=%0d want=%0d", d, nops, exp_ops(d)); else passed++;
    total++; if (bad != 0) $display("FAIL known_stream_gaps d=%0d got=%0d want=0", d, bad); else passed++;
    total++; if (c1 !== 3'b111) $display("FAIL known_cycle1 got=%b want=111", c1); else passed++;
    total++; if (c1d !== 8'(c)) $display("FAIL known_cycle1_limb got=%h want=%h", c1d, 8'(c)); else passed++;
    total++; if (!dn) $display("FAIL known_done got=0 want=1"); else passed++;
  endtask

  task automatic test_zero_exp();
    logic [15:0] res; int nops, bad; logic [2:0] c1; logic [7:0] c1d; bit dn, tmo;
    load($urandom_range(1, 240), 0);
    run(res, nops, bad, c1, c1d, dn, tmo);
    total++; if (res !== 16'd1) $display("FAIL zero_exp_result got=%0d want=1", res); else passed++;
    total++; if (nops != exp_ops(0)) $display("FAIL zero_exp_ops got=%0d want=%0d", nops, exp_ops(0)); else passed++;
    total++; if (tmo || !dn) $display("FAIL zero_exp_done tmo=%0d done=%0d want tmo=0 done=1", tmo, dn); else passed++;
  endtask

  task automatic test_random();
    logic [15:0] res; int nops, bad; logic [2:0] c1; logic [7:0] c1d; bit dn, tmo;
    int c, d;
    for (int i = 0; i < 6; i++) begin
      c = $urandom_range(1, 240);
      d = $urandom_range(0, 65535);
      load(c, d);
      run(res, nops, bad, c1, c1d, dn, tmo);
      total++; if (res !== 16'(ref_exp(c, d))) $display("FAIL random_result c=%0d d=%0d got=%0d want=%0d", c, d, res, ref_exp(c, d)); else passed++;
      total++; if (nops != exp_ops(d) || bad != 0) $display("FAIL random_ops d=%0d got=%0d/%0d want=%0d/0", d, nops, bad, exp_ops(d)); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] res, exp_v; int nops, bad, o0, cyc; logic [2:0] c1; logic [7:0] c1d; bit dn, tmo, busy_ok, idle_ok;
    int c, d;
    c = $urandom_range(1, 240);
    d = $urandom_range(1, 65535);
    exp_v = 16'(ref_exp(c, d));
    load(c, d);
    o0 = ops; res = '0; busy_ok = 1; idle_ok = 1; cyc = 0;
    @(negedge clk); m.start = 1'b1;
    @(negedge clk); m.start = 1'b0;
    while (!m.done && cyc < 4000) begin
      m.start = cyc == 3 || cyc == 20;
      m.ld_en = cyc == 5;
      m.ld_sel = 2'd3;
      m.ld_addr = 1'b1;
      m.ld_data = ~8'(d >> 8);
      if (!m.busy) busy_ok = 0;
      if (m.res_valid && m.res_ready) res[int'(dut.cnt)*DW +: DW] = m.res_data;
      cyc++;
      @(negedge clk);
    end
    m.ld_en = 1'b0;
    total++; if (cyc >= 4000) $display("FAIL b2b_timeout cycles=%0d", cyc); else passed++;
    m.start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      m.start = 1'b0;
      if (m.busy || m.mp_start) idle_ok = 0;
    end
    total++; if (!busy_ok) $display("FAIL b2b_busy got=dropped want=held"); else passed++;
    total++; if (res !== exp_v) $display("FAIL b2b_result got=%0d want=%0d", res, exp_v); else passed++;
    total++; if (ops - o0 != exp_ops(d)) $display("FAIL b2b_ops got=%0d want=%0d", ops - o0, exp_ops(d)); else passed++;
    total++; if (!idle_ok) $display("FAIL b2b_start_in_done got=started want=ignored"); else passed++;
    c = $urandom_range(1, 240);
    load_sel(0, c);
    load_sel(2, int'(rval));
    run(res, nops, bad, c1, c1d, dn, tmo);
    total++; if (res !== 16'(ref_exp(c, d))) $display("FAIL b2b_store_survives got=%0d want=%0d", res, ref_exp(c, d)); else passed++;
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_v; logic [7:0] first; bit stable; int c, d;
    c = $urandom_range(1, 240);
    d = $urandom_range(1, 65535);
    exp_v = 16'(ref_exp(c, d));
    load(c, d);
    m.res_ready = 1'b0;
    @(negedge clk); m.start = 1'b1;
    @(negedge clk); m.start = 1'b0;
    for (int i = 0; i < 4000 && !m.res_valid; i++) @(negedge clk);
    total++; if (!m.res_valid) $display("FAIL bp_timeout res_valid=0 want=1"); else passed++;
    first = m.res_data;
    stable = 1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (!m.res_valid || m.res_data !== first || m.done) stable = 0;
    end
    total++; if (!stable) $display("FAIL bp_stable got=changed want=held data=%h", first); else passed++;
    total++; if (first !== exp_v[7:0]) $display("FAIL bp_limb0 got=%h want=%h", first, exp_v[7:0]); else passed++;
    m.res_ready = 1'b1;
    @(negedge clk);
    total++; if (!m.res_valid || m.done || m.res_data !== exp_v[15:8]) $display("FAIL bp_limb1 valid=%0d done=%0d data=%h want 1/0/%h", m.res_valid, m.done, m.res_data, exp_v[15:8]); else passed++;
    @(negedge clk);
    total++; if (!m.done || m.busy) $display("FAIL bp_done done=%0d busy=%0d want 1/0", m.done, m.busy); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [15:0] res; int nops, bad, o0; logic [2:0] c1; logic [7:0] c1d; bit dn, tmo, hit, idle_ok;
    int c, d;
    c = $urandom_range(1, 240);
    d = 32'h8000 | $urandom_range(0, 32767);
    load(c, d);
    o0 = ops; hit = 0; idle_ok = 1;
    @(negedge clk); m.start = 1'b1;
    @(negedge clk); m.start = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(posedge clk);
      if (ops - o0 == 2 && m.mp_out_valid) hit = 1;
    end
    total++; if (!hit) $display("FAIL rstmid_reach_sqr got=0 want=1"); else passed++;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    total++; if ({m.busy, m.done, m.res_valid, m.mp_start, m.mp_in_valid} !== 5'b0) $display("FAIL rstmid_ctrl got=%b want=00000", {m.busy, m.done, m.res_valid, m.mp_start, m.mp_in_valid}); else passed++;
    total++; if (m.res_data !== 8'h00 || m.mp_in_data !== 8'h00) $display("FAIL rstmid_data got=%h/%h want=00/00", m.res_data, m.mp_in_data); else passed++;
    reset = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (m.busy || m.mp_in_valid) idle_ok = 0;
    end
    total++; if (!idle_ok) $display("FAIL rstmid_stay_idle got=active want=idle"); else passed++;
    load(c, d);
    run(res, nops, bad, c1, c1d, dn, tmo);
    total++; if (tmo || res !== 16'(ref_exp(c, d))) $display("FAIL rstmid_rerun got=%0d want=%0d tmo=%0d", res, ref_exp(c, d), tmo); else passed++;
  endtask

  initial begin
    m.ld_en = 1'b0; m.ld_sel = '0; m.ld_addr = '0; m.ld_data = '0;
    m.start = 1'b0; m.res_ready = 1'b1;
    rval = R % N;
    tval = (rval * rval) % N;
    rinv = 0;
    for (longint x = 1; x < N; x++) if ((x * rval) % N == 1) rinv = x;
    test_reset();
    test_known(5, 3, 16'd125);
    test_known(2, 10, 16'd60);
    test_zero_exp();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
